// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path (and its receive-side twin).
// Contents:
//   state_t           - transmitter FSM state encoding
//   PARITY_*          - parity mode selectors for the PARITY parameter
//   DEFAULT_CLK_DIV   - bit period, in board-clock cycles, for the default link rate
//   parity_bit()      - parity of a data word for a given mode
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_CLK_DIV = 100;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-stream interface between the move encoder (master) and the UART
// transmitter (slave).
//   tx_data  - byte to send, valid with tx_valid
//   tx_valid - producer has a byte
//   tx_ready - transmitter can accept a byte
//   tx_done  - one-cycle pulse when a frame completes
//   tx       - serial line, idles high
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 tx;

  modport master (output tx_data, output tx_valid,
                  input  tx_ready, input tx_done, input tx);
  modport slave  (input  tx_data, input tx_valid,
                  output tx_ready, output tx_done, output tx);
endinterface

// File: rtl/uart_tx_serializer_baud_gen.sv
// Bit-period counter shared by the UART transmit and receive paths.
// Ports:
//   pclk    - clock
//   rst     - synchronous reset, active-low
//   clear   - restart the period (start of a frame)
//   enable  - count while a frame is in progress
//   bit_end - one-cycle strobe in the last cycle of each bit period
module uart_baud_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic pclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_r;
  logic             at_end_s;

  assign at_end_s = (cnt_r == CNT_W'(CLK_DIV - 1));
  assign bit_end  = enable && at_end_s;

  // Period counter; wraps at every bit boundary so timing never accumulates error.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= at_end_s ? '0 : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame transmitter: accepts one word per valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, optional parity, and STOP_BITS stop
// bits. All outputs come straight from flops.
// Ports:
//   pclk - clock
//   rst  - synchronous reset, active-low
//   bus  - slave side of uart_tx_serializer_if (tx_data/tx_valid/tx_ready/tx_done/tx)
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 pclk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);

  localparam int IDX_W = $clog2(DATA_BITS);

  state_t               state_r,    state_nxt;
  logic [DATA_BITS-1:0] shift_r,    shift_nxt;
  logic [IDX_W-1:0]     bit_idx_r,  bit_idx_nxt;
  logic                 stop_idx_r, stop_idx_nxt;
  logic                 parity_r,   parity_nxt;
  logic                 tx_r,       tx_nxt;
  logic                 ready_r,    ready_nxt;
  logic                 done_r,     done_nxt;
  logic                 handshake_s;
  logic                 bit_end_s;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .pclk    (pclk),
    .rst     (rst),
    .clear   (handshake_s),
    .enable  (state_r != ST_IDLE),
    .bit_end (bit_end_s)
  );

  assign bus.tx       = tx_r;
  assign bus.tx_ready = ready_r;
  assign bus.tx_done  = done_r;

  // Next-state logic; line value and flags are computed one cycle ahead so they leave on flops.
  always_comb begin
    state_nxt    = state_r;
    shift_nxt    = shift_r;
    bit_idx_nxt  = bit_idx_r;
    stop_idx_nxt = stop_idx_r;
    parity_nxt   = parity_r;
    tx_nxt       = tx_r;
    ready_nxt    = ready_r;
    done_nxt     = 1'b0;
    handshake_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.tx_valid && ready_r) begin
          handshake_s  = 1'b1;
          shift_nxt    = bus.tx_data;
          parity_nxt   = parity_bit(8'(bus.tx_data), PARITY);
          bit_idx_nxt  = '0;
          stop_idx_nxt = 1'b0;
          state_nxt    = ST_START;
          tx_nxt       = 1'b0;
          ready_nxt    = 1'b0;
        end else begin
          tx_nxt    = 1'b1;
          ready_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt = ST_DATA;
          tx_nxt    = shift_r[0];
        end else begin
          tx_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              state_nxt = ST_PARITY;
              tx_nxt    = parity_r;
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            // Next bit is the one that moves into the LSB after the shift.
            shift_nxt   = shift_r >> 1;
            tx_nxt      = shift_r[1];
            bit_idx_nxt = bit_idx_r + IDX_W'(1);
          end
        end else begin
          tx_nxt = shift_r[0];
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nxt = ST_STOP;
          tx_nxt    = 1'b1;
        end else begin
          tx_nxt = parity_r;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (stop_idx_r == 1'(STOP_BITS - 1)) begin
            // Frame complete: first IDLE cycle carries tx_done and tx_ready together.
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end else begin
          stop_idx_nxt = stop_idx_r;
        end
        tx_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without tx_done.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      shift_r    <= shift_nxt;
      bit_idx_r  <= bit_idx_nxt;
      stop_idx_r <= stop_idx_nxt;
      parity_r   <= parity_nxt;
      tx_r       <= tx_nxt;
      ready_r    <= ready_nxt;
      done_r     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer. Four instances with CLK_DIV=4:
//   dut 0: 8N1, dut 1: 8E1, dut 2: 8O1, dut 3: 8N2.
// Inputs are driven and outputs sampled on the falling edge of pclk.
module tb_uart_tx_serializer;

  localparam int CLK = 4;

  logic       pclk;
  logic       rst;
  logic [7:0] data_v [4];
  logic [3:0] valid_v;
  logic [3:0] tx_w;
  logic [3:0] ready_w;
  logic [3:0] done_w;

  int checks;
  int failures;

  uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_data = data_v[0];
  assign if1.tx_data = data_v[1];
  assign if2.tx_data = data_v[2];
  assign if3.tx_data = data_v[3];
  assign if0.tx_valid = valid_v[0];
  assign if1.tx_valid = valid_v[1];
  assign if2.tx_valid = valid_v[2];
  assign if3.tx_valid = valid_v[3];
  assign tx_w    = {if3.tx, if2.tx, if1.tx, if0.tx};
  assign ready_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign done_w  = {if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};

  uart_tx_serializer #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.pclk(pclk), .rst(rst), .bus(if0));
  uart_tx_serializer #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut1 (.pclk(pclk), .rst(rst), .bus(if1));
  uart_tx_serializer #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut2 (.pclk(pclk), .rst(rst), .bus(if2));
  uart_tx_serializer #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    dut3 (.pclk(pclk), .rst(rst), .bus(if3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag, input logic exp_done);
    chk($sformatf("%s_tx", tag), tx_w[d], 1'b1);
    chk($sformatf("%s_ready", tag), ready_w[d], 1'b1);
    chk($sformatf("%s_done", tag), done_w[d], exp_done);
  endtask

  // Present a word for one handshake edge; returns at the first frame cycle.
  task automatic send(input int d, input logic [7:0] data);
    @(negedge pclk);
    data_v[d]  = data;
    valid_v[d] = 1'b1;
    @(negedge pclk);
    valid_v[d] = 1'b0;
  endtask

  // Checks every cycle of a frame (bits[0] = start bit), ending on the first IDLE cycle.
  // inject >= 0 pulses tx_valid with 0x33 at that frame cycle.
  task automatic check_frame(input int d, input logic [15:0] bits, input int nbits,
                             input string tag, input int inject);
    for (int i = 0; i < nbits * CLK; i++) begin
      if (i == inject) begin
        data_v[d]  = 8'h33;
        valid_v[d] = 1'b1;
      end else if (inject >= 0 && i == inject + 1) begin
        valid_v[d] = 1'b0;
      end
      chk($sformatf("%s_tx_c%0d", tag, i), tx_w[d], bits[i / CLK]);
      chk($sformatf("%s_ready_c%0d", tag, i), ready_w[d], 1'b0);
      chk($sformatf("%s_done_c%0d", tag, i), done_w[d], 1'b0);
      @(negedge pclk);
    end
    check_idle(d, $sformatf("%s_end", tag), 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    valid_v  = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset state on all instances.
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 4; d++) check_idle(d, $sformatf("reset_d%0d", d), 1'b0);
    rst = 1'b1;
    @(negedge pclk);

    // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop -> 40 cycles.
    send(0, 8'hA5);
    check_frame(0, 16'b0000_0011_0100_1010, 10, "a5", -1);
    @(negedge pclk);
    check_idle(0, "a5_after", 1'b0);

    // 8E1 0x07: three ones -> parity 1.
    send(1, 8'h07);
    check_frame(1, 16'b0000_0110_0000_1110, 11, "even07", -1);
    @(negedge pclk);
    check_idle(1, "even07_after", 1'b0);

    // 8O1 0x07: parity 0.
    send(2, 8'h07);
    check_frame(2, 16'b0000_0100_0000_1110, 11, "odd07", -1);
    @(negedge pclk);
    check_idle(2, "odd07_after", 1'b0);

    // 8N2 0xFF: two stop bits -> 44 cycles.
    send(3, 8'hFF);
    check_frame(3, 16'b0000_0111_1111_1110, 11, "n2ff", -1);
    @(negedge pclk);
    check_idle(3, "n2ff_after", 1'b0);

    // Back-to-back with tx_valid held: 0x11 then 0x22, start edges 41 cycles apart.
    @(negedge pclk);
    data_v[0]  = 8'h11;
    valid_v[0] = 1'b1;
    @(negedge pclk);
    data_v[0]  = 8'h22;
    check_frame(0, 16'b0000_0010_0010_0010, 10, "b2b11", -1);
    @(negedge pclk);
    valid_v[0] = 1'b0;
    check_frame(0, 16'b0000_0010_0100_0100, 10, "b2b22", -1);
    @(negedge pclk);
    check_idle(0, "b2b_after", 1'b0);

    // 0x3C with a 0x33 pulse mid-frame: ignored, no second frame.
    send(0, 8'h3C);
    check_frame(0, 16'b0000_0010_0111_1000, 10, "mid3c", 10);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      check_idle(0, $sformatf("mid_quiet%0d", i), 1'b0);
    end

    // 0xC3 abandoned by reset during data bit 3 (frame cycles 16..19).
    send(0, 8'hC3);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("rstf_tx_c%0d", i), tx_w[0], (i < 4) ? 1'b0 :
          ((i < 12) ? 1'b1 : 1'b0));
      @(negedge pclk);
    end
    rst = 1'b0;
    @(negedge pclk);
    check_idle(0, "rst_mid", 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check_idle(0, $sformatf("rst_quiet%0d", i), 1'b0);
    end

    // 0x5A after reset release.
    send(0, 8'h5A);
    check_frame(0, 16'b0000_0010_1011_0100, 10, "post5a", -1);
    @(negedge pclk);
    check_idle(0, "post5a_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
